mux_scan_nw: RTL

MUX_SCAN_NW -- requirements
Module: mux_scan_nw

---
 rtl/mux_scan_nw.sv | 96 +++++++++
 1 files changed

// File: rtl/mux_scan_nw.sv
// Registered channel multiplexer with a STATIC (select-driven) mode and a SCAN mode
// that steps through the channels, dwelling i_dwell+1 cycles on each one.
module mux_scan_nw #(
    parameter int              WIDTH    = 4,
    parameter int              CHANNELS = 6,
    parameter int              SEL_W    = 3,
    parameter int              DWELL_W  = 8,
    parameter logic [WIDTH-1:0] FILL    = '1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [CHANNELS*WIDTH-1:0]   i_in,
    input  logic [SEL_W-1:0]            i_sel,
    input  logic                        i_mode,
    input  logic [DWELL_W-1:0]          i_dwell,
    input  logic                        i_hold,
    output logic [WIDTH-1:0]            o_out,
    output logic [SEL_W-1:0]            o_chan,
    output logic                        o_strobe
);

    typedef enum logic {
        ST_STATIC = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] cnt_eff;
    logic [SEL_W-1:0]   chan_q, chan_d;
    logic [SEL_W-1:0]   chan_next;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               strobe_q, strobe_d;

    // A scan entered from STATIC always begins its dwell from zero.
    always_comb begin
        cnt_eff = (state_q == ST_SCAN) ? cnt_q : '0;
    end

    // Indices left out of range by STATIC mode wrap to channel 0 like the last channel.
    always_comb begin
        if (int'(chan_q) >= CHANNELS - 1) begin
            chan_next = '0;
        end else begin
            chan_next = chan_q + SEL_W'(1);
        end
    end

    always_comb begin
        state_d  = i_mode ? ST_SCAN : ST_STATIC;
        cnt_d    = '0;
        chan_d   = chan_q;
        strobe_d = 1'b0;
        if (!i_mode) begin
            chan_d = i_sel;
        end else if (i_hold) begin
            cnt_d = cnt_eff;
        end else if (cnt_eff >= i_dwell) begin
            chan_d   = chan_next;
            strobe_d = 1'b1;
        end else begin
            cnt_d = cnt_eff + DWELL_W'(1);
        end
    end

    // Data is picked from the index being registered so o_out and o_chan never disagree.
    always_comb begin
        out_d = FILL;
        for (int k = 0; k < CHANNELS; k++) begin
            if (chan_d == SEL_W'(k)) begin
                out_d = i_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_STATIC;
            cnt_q    <= '0;
            chan_q   <= '0;
            out_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            chan_q   <= chan_d;
            out_q    <= out_d;
            strobe_q <= strobe_d;
        end
    end

    assign o_out    = out_q;
    assign o_chan   = chan_q;
    assign o_strobe = strobe_q;

endmodule
